// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and its consumer: a circular buffer with
// first-word-fall-through read data, registered flags and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   count_next;
    logic              do_write;
    logic              do_read;
    logic              drop;

    // A pop from a full queue frees the slot, so the write is still accepted.
    always_comb begin
        do_read  = rd && !empty;
        do_write = wr && (!full || rd);
        drop     = wr && full && !rd;
        count_next = count;
        unique case ({do_write, do_read})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            mem[w_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (do_write) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (do_read) begin
                r_ptr <= r_ptr + 1'b1;
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == DEPTH_C);
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign r_data = mem[r_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: a vector table for basic
// ordering/flag behaviour plus hand-written full, wrap and reset sequences.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic [7:0] w_data;
    logic       rd;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       clr_overrun;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .w_data      (w_data),
        .rd          (rd),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] wd;
        int         cnt;
        logic       e;
        logic       f;
        logic       ov;
        logic       rchk;
        logic [7:0] rdx;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input logic e,
                               input logic f, input logic ov);
        check({tag, ".count"},   32'(count),   32'(cnt));
        check({tag, ".empty"},   32'(empty),   32'(e));
        check({tag, ".full"},    32'(full),    32'(f));
        check({tag, ".overrun"}, 32'(overrun), 32'(ov));
    endtask

    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        wr = w;
        rd = r;
        clr_overrun = c;
        w_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        clr_overrun = 1'b0;
    endtask

    initial begin
        // wr rd clr data  cnt e f ov rchk rdx
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h41, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h42, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h43, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 8'h66, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        reset = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
        clr_overrun = 1'b0;
        w_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_state("reset", 0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].wd);
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].e, vecs[i].f, vecs[i].ov);
            if (vecs[i].rchk) begin
                check($sformatf("vec%0d.r_data", i), 32'(r_data), 32'(vecs[i].rdx));
            end
        end

        // Fill to full, then a dropped write.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i));
            check($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
        end
        check_state("full", 16, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'hAA);
        check_state("drop", 16, 1'b0, 1'b1, 1'b1);
        check("drop.head", 32'(r_data), 32'h00);
        step(1'b1, 1'b0, 1'b1, 8'hBB);
        check_state("set_beats_clr", 16, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("clr", 16, 1'b0, 1'b1, 1'b0);

        // Simultaneous write and pop while full.
        step(1'b1, 1'b1, 1'b0, 8'h55);
        check_state("full_wr_rd", 16, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain%0d.r_data", i), 32'(r_data), (i == 16) ? 32'h55 : 32'(i));
            step(1'b0, 1'b1, 1'b0, 8'h00);
        end
        check_state("drained", 0, 1'b1, 1'b0, 1'b0);

        // Pointer wrap with three words held.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i));
        end
        for (int i = 0; i < 40; i++) begin
            check($sformatf("wrap%0d.r_data", i), 32'(r_data), 32'(i));
            step(1'b1, 1'b1, 1'b0, 8'(i + 3));
            check($sformatf("wrap%0d.count", i), 32'(count), 32'd3);
        end
        for (int i = 40; i < 43; i++) begin
            check($sformatf("wrapdrain%0d.r_data", i), 32'(r_data), 32'(i));
            step(1'b0, 1'b1, 1'b0, 8'h00);
        end
        check_state("wrap_end", 0, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation with a write in the reset cycle.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        end
        check_state("pre_reset", 5, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h77);
        reset = 1'b0;
        check_state("mid_reset", 0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_state("post_reset_idle", 0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h99);
        check_state("post_reset_wr", 1, 1'b0, 1'b0, 1'b0);
        check("post_reset.r_data", 32'(r_data), 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between the UART receiver and the consuming logic (keyboard/command decoder, host interface). It captures each byte on the receiver's one-cycle done strobe and queues it in a circular buffer. The consumer reads bytes at its own pace through a first-word-fall-through interface. Dropped bytes are reported through a sticky overrun flag.

## Interface
- `DATA_W`, default 8: width of a queued word; matches the receiver's `dout`.
- `ADDR_W`, default 4: address width; depth is 2**ADDR_W entries (16 by default).

Ports:
- `clk`  in  1: system clock, the single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `wr`  in  1: write strobe; connect to the receiver's `rx_done_tick`.
- `w_data`  in  DATA_W: write data; connect to the receiver's `dout`.
- `rd`  in  1: pop strobe from the consumer.
- `r_data`  out  DATA_W: head-of-queue word (first-word-fall-through).
- `empty`  out  1: queue holds 0 words.
- `full`  out  1: queue holds 2**ADDR_W words.
- `count`  out  ADDR_W+1: number of words currently held.
- `overrun`  out  1: sticky; set when a write is dropped.
- `clr_overrun`  in  1: clears `overrun`.

## Operation
- Storage: register array of 2**ADDR_W × DATA_W, not reset.
- Pointers: `w_ptr` and `r_ptr`, ADDR_W bits each, wrap modulo depth with no special case.
- Occupancy: `count` register, ADDR_W+1 bits, 0..2**ADDR_W.
- `empty` and `full` are registered, updated on the same edge as `count`.
- Per-cycle actions, decided by `{wr, rd}` and the current flags:
  - wr=1, rd=0, not full: store `w_data` at `w_ptr`, increment `w_ptr`, increment `count`.
  - wr=1, rd=0, full: drop the word, set `overrun`. Pointers and count unchanged.
  - wr=0, rd=1, not empty: increment `r_ptr`, decrement `count`.
  - wr=0, rd=1, empty: ignored. No state change, no error flag.
  - wr=1, rd=1, not empty and not full: write and pop both happen; `count` unchanged.
  - wr=1, rd=1, empty: the pop is ignored and the write proceeds. Queue goes to 1 word.
  - wr=1, rd=1, full: the pop frees a slot, so the write is accepted. `count` stays at max and `overrun` is not set.
- `r_data` is combinational `mem[r_ptr]`.
  - Valid whenever `empty`=0.
  - Don't-care while `empty`=1.
- `overrun` priority: set wins over `clr_overrun` in the same cycle. Otherwise `clr_overrun`=1 clears it.
- Flag update rules:
  - `full` becomes 1 when a net write brings `count` to 2**ADDR_W.
  - `empty` becomes 1 when a net pop brings `count` to 0.

## Timing
- Reset (synchronous, sampled on `clk` rising edge with `reset`=1):
  - `w_ptr`=0, `r_ptr`=0, `count`=0.
  - `empty`=1, `full`=0, `overrun`=0.
  - Array contents are preserved but meaningless.
  - Reset mid-operation discards all queued words. Any `wr`/`rd` in the reset cycle is ignored.
- Write latency: a write accepted at edge N makes `empty`=0, `count`+1, and `r_data` valid after edge N. An immediate `rd` in the following cycle pops it.
- Pop latency: `rd` sampled at edge N advances `r_ptr`. The next word appears on `r_data` combinationally after edge N.
- Throughput: one write and one pop per cycle sustained, no bubbles.
- The receiver asserts `wr` at most once per byte time, one cycle wide. The block does not depend on that spacing; back-to-back `wr` must work.
- Edge latency for `full`, `empty`, `count`, `overrun`: each is valid one edge after the causing strobe.

## Test plan
- Reset then idle:
  - Stimulus: hold `reset` 2 cycles, then release with `wr`=`rd`=0.
  - Response: `empty`=1, `full`=0, `count`=0, `overrun`=0. A `rd` pulse leaves all outputs unchanged.
- Ordered fill/drain:
  - Stimulus: write 0x41, 0x42, 0x43 on consecutive cycles, then pop 3 times.
  - Response: `r_data` shows 0x41, 0x42, 0x43 in order; `count` goes 1,2,3,2,1,0; `empty`=1 after the third pop.
- Full and overrun:
  - Stimulus: write 16 words 0x00..0x0F, then write 0xAA.
  - Response: `full`=1 after the 16th write; 0xAA is dropped and `overrun`=1. Draining then returns 0x00..0x0F with no 0xAA.
  - Follow-up: pulse `clr_overrun`; `overrun`=0.
- Simultaneous wr/rd at boundaries:
  - Full case: with the queue full, assert `wr`=`rd`=1 with 0x55. Head pops; `count` stays 16; `overrun` stays 0; 0x55 is last out.
  - Empty case: with the queue empty, assert `wr`=`rd`=1 with 0x66. `count`=1 and `r_data`=0x66.
- Pointer wrap:
  - Stimulus: run 40 interleaved write/pop pairs with incrementing data, keeping 3 words held.
  - Response: all 40 values are read in order; `count` never exceeds 4.
- Reset mid-operation:
  - Stimulus: with 5 words queued, assert `reset` 1 cycle while `wr`=1.
  - Response: `empty`=1, `count`=0; the word presented in the reset cycle is not stored.
